// File: rtl/axil_wr_resp.sv
// AXI4-Lite write-channel slave: independent AW/W buffers, a latency-programmable
// commit into a byte-strobed word memory, and a held B response.
module axil_wr_resp #(
  parameter int DEPTH      = 1024,
  parameter int WR_LATENCY = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [31:0]              awaddr,
  input  logic                     wvalid,
  output logic                     wready,
  input  logic [31:0]              wdata,
  input  logic [3:0]               wstrb,
  output logic                     bvalid,
  input  logic                     bready,
  output logic [1:0]               bresp,
  input  logic [$clog2(DEPTH)-1:0] dbg_addr,
  output logic [31:0]              dbg_rdata
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, WRITE, RESP} state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic          aw_full;
  logic          w_full;
  logic [29:0]   aw_word;
  logic [31:0]   w_data;
  logic [3:0]    w_strb;
  logic [31:0]   mem [DEPTH];

  logic          commit;
  logic          in_range;
  logic [AW-1:0] widx;
  logic          unused_addr_lsbs;

  // Byte offset within the word carries no meaning for a word-addressed store.
  assign unused_addr_lsbs = ^awaddr[1:0];

  assign awready   = ~aw_full;
  assign wready    = ~w_full;
  assign widx      = aw_word[AW-1:0];
  assign in_range  = ({2'b00, aw_word} < 32'(DEPTH));
  assign commit    = (state == WRITE) && (cnt == '0);
  assign dbg_rdata = mem[dbg_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
    end else begin
      if (awvalid && !aw_full) begin
        aw_full <= 1'b1;
        aw_word <= awaddr[31:2];
      end
      if (wvalid && !w_full) begin
        w_full <= 1'b1;
        w_data <= wdata;
        w_strb <= wstrb;
      end
      case (state)
        IDLE: begin
          if (aw_full && w_full) begin
            state <= WRITE;
            cnt   <= 4'(WR_LATENCY);
          end
        end
        WRITE: begin
          if (cnt != '0) begin
            cnt <= cnt - 4'd1;
          end else begin
            // Buffers free at commit so the next AW/W can land during RESP.
            aw_full <= 1'b0;
            w_full  <= 1'b0;
            bvalid  <= 1'b1;
            bresp   <= in_range ? RESP_OKAY : RESP_SLVERR;
            state   <= RESP;
          end
        end
        RESP: begin
          if (bready) begin
            bvalid <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory is deliberately unreset; a reset edge suppresses a pending commit.
  always_ff @(posedge clk) begin
    if (!rst && commit && in_range) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_strb[i]) mem[widx][8*i +: 8] <= w_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axil_wr_resp.sv
// Directed bench for axil_wr_resp: three instances (latency 0, 3, 5) share stimulus;
// each scenario checks only the instance it targets.
module tb_axil_wr_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        awvalid, wvalid, bready;
  logic [31:0] awaddr, wdata;
  logic [3:0]  wstrb;
  logic [9:0]  dbg_addr;
  logic        awready [3];
  logic        wready  [3];
  logic        bvalid  [3];
  logic [1:0]  bresp   [3];
  logic [31:0] dbg_rdata [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axil_wr_resp #(.DEPTH(1024), .WR_LATENCY(0)) u_lat0 (
    .clk(clk), .rst(rst), .awvalid(awvalid), .awready(awready[0]), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready[0]), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid[0]), .bready(bready), .bresp(bresp[0]),
    .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata[0]));

  axil_wr_resp #(.DEPTH(1024), .WR_LATENCY(3)) u_lat3 (
    .clk(clk), .rst(rst), .awvalid(awvalid), .awready(awready[1]), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready[1]), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid[1]), .bready(bready), .bresp(bresp[1]),
    .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata[1]));

  axil_wr_resp #(.DEPTH(1024), .WR_LATENCY(5)) u_lat5 (
    .clk(clk), .rst(rst), .awvalid(awvalid), .awready(awready[2]), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready[2]), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid[2]), .bready(bready), .bresp(bresp[2]),
    .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata[2]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Single AW+W at one edge, then waits for bvalid; lat = edges after the handshake
  // edge (-1 on timeout). Leaves one more edge for the B handshake when bready=1.
  task automatic do_write(input int idx, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output int lat, output logic [1:0] r);
    awvalid = 1'b1; awaddr = a; wvalid = 1'b1; wdata = d; wstrb = s;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    lat = -1;
    r = 2'b11;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (bvalid[idx]) begin
        lat = i;
        r = bresp[idx];
        break;
      end
    end
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 3; i += 2) begin
      checks++;
      if ({awready[i], wready[i], bvalid[i], bresp[i]} !== 5'b11000) begin
        errors++;
        $display("FAIL reset_state inst%0d: got aw/w/bv/br=%b%b%b%b want 11000",
                 i, awready[i], wready[i], bvalid[i], bresp[i]);
      end
    end
  endtask

  task automatic test_basic();
    bready = 1'b1;
    awvalid = 1'b1; awaddr = 32'h0000_0010; wvalid = 1'b1; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    checks++;
    if ({awready[0], wready[0], bvalid[0]} !== 3'b000) begin
      errors++;
      $display("FAIL basic_accept: aw/w/bv=%b%b%b want 000", awready[0], wready[0], bvalid[0]);
    end
    tick();
    checks++;
    if (bvalid[0] !== 1'b0) begin
      errors++;
      $display("FAIL basic_early_bvalid: got %b want 0", bvalid[0]);
    end
    tick();
    dbg_addr = 10'd4;
    #1;
    checks++;
    if (bvalid[0] !== 1'b1 || bresp[0] !== 2'b00 || dbg_rdata[0] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL basic_commit: bvalid=%b bresp=%b mem4=%h want 1 00 deadbeef",
               bvalid[0], bresp[0], dbg_rdata[0]);
    end
    tick();
    checks++;
    if (bvalid[0] !== 1'b0 || awready[0] !== 1'b1) begin
      errors++;
      $display("FAIL basic_b_one_cycle: bvalid=%b awready=%b want 0 1", bvalid[0], awready[0]);
    end
  endtask

  task automatic test_strobe_order();
    wvalid = 1'b1; wdata = 32'h1122_3344; wstrb = 4'b0101;
    tick();
    wvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (awready[0] !== 1'b1 || wready[0] !== 1'b0 || bvalid[0] !== 1'b0) begin
        errors++;
        $display("FAIL strobe_w_only_wait%0d: aw/w/bv=%b%b%b want 100",
                 i, awready[0], wready[0], bvalid[0]);
      end
      tick();
    end
    awvalid = 1'b1; awaddr = 32'h0000_0010;
    tick();
    awvalid = 1'b0;
    checks++;
    if (awready[0] !== 1'b0 || wready[0] !== 1'b0) begin
      errors++;
      $display("FAIL strobe_both_full: aw/w=%b%b want 00", awready[0], wready[0]);
    end
    tick();
    tick();
    dbg_addr = 10'd4;
    #1;
    checks++;
    if (bvalid[0] !== 1'b1 || awready[0] !== 1'b1 || wready[0] !== 1'b1 ||
        dbg_rdata[0] !== 32'hDE22_BE44) begin
      errors++;
      $display("FAIL strobe_commit: bv/aw/w=%b%b%b mem4=%h want 111 de22be44",
               bvalid[0], awready[0], wready[0], dbg_rdata[0]);
    end
    tick();
  endtask

  task automatic test_out_of_range();
    int lat;
    logic [1:0] r;
    do_reset();
    bready = 1'b1;
    dbg_addr = 10'd0;
    do_write(0, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, lat, r);
    checks++;
    if (lat != 2 || r !== 2'b00 || dbg_rdata[0] !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL oor_setup: lat=%0d resp=%b mem0=%h want 2 00 cafef00d", lat, r, dbg_rdata[0]);
    end
    do_write(0, 32'h0000_1000, 32'hFFFF_FFFF, 4'hF, lat, r);
    checks++;
    if (lat != 2 || r !== 2'b10 || dbg_rdata[0] !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL oor_slverr: lat=%0d resp=%b mem0=%h want 2 10 cafef00d", lat, r, dbg_rdata[0]);
    end
    do_write(0, 32'h0000_0003, 32'h1234_5678, 4'h0, lat, r);
    checks++;
    if (lat != 2 || r !== 2'b00 || dbg_rdata[0] !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL zero_strobe: lat=%0d resp=%b mem0=%h want 2 00 cafef00d", lat, r, dbg_rdata[0]);
    end
  endtask

  task automatic test_latency_backpressure();
    int lat;
    do_reset();
    bready = 1'b0;
    awvalid = 1'b1; awaddr = 32'h0000_001C; wvalid = 1'b1; wdata = 32'h0102_0304; wstrb = 4'hF;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bvalid[1]) begin
        lat = i;
        break;
      end
    end
    checks++;
    if (lat != 5 || bresp[1] !== 2'b00) begin
      errors++;
      $display("FAIL lat3_first: latency=%0d bresp=%b want 5 00", lat, bresp[1]);
    end
    awvalid = 1'b1; awaddr = 32'h0000_0020; wvalid = 1'b1; wdata = 32'hA5A5_A5A5; wstrb = 4'hF;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    checks++;
    if (awready[1] !== 1'b0 || wready[1] !== 1'b0) begin
      errors++;
      $display("FAIL lat3_second_accept: aw/w=%b%b want 00", awready[1], wready[1]);
    end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (bvalid[1] !== 1'b1 || bresp[1] !== 2'b00) begin
        errors++;
        $display("FAIL lat3_hold%0d: bvalid=%b bresp=%b want 1 00", i, bvalid[1], bresp[1]);
      end
      tick();
    end
    bready = 1'b1;
    tick();
    checks++;
    if (bvalid[1] !== 1'b0) begin
      errors++;
      $display("FAIL lat3_b_handshake: bvalid=%b want 0", bvalid[1]);
    end
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bvalid[1]) begin
        lat = i;
        break;
      end
    end
    dbg_addr = 10'd8;
    #1;
    checks++;
    if (lat != 5 || dbg_rdata[1] !== 32'hA5A5_A5A5) begin
      errors++;
      $display("FAIL lat3_second: latency=%0d mem8=%h want 5 a5a5a5a5", lat, dbg_rdata[1]);
    end
    dbg_addr = 10'd7;
    #1;
    checks++;
    if (dbg_rdata[1] !== 32'h0102_0304) begin
      errors++;
      $display("FAIL lat3_first_data: mem7=%h want 01020304", dbg_rdata[1]);
    end
    tick();
  endtask

  task automatic test_reset_mid_write();
    int lat;
    logic [1:0] r;
    do_reset();
    bready = 1'b1;
    do_write(2, 32'h0000_0040, 32'h55AA_55AA, 4'hF, lat, r);
    checks++;
    if (lat != 7 || r !== 2'b00) begin
      errors++;
      $display("FAIL lat5_setup: latency=%0d resp=%b want 7 00", lat, r);
    end
    awvalid = 1'b1; awaddr = 32'h0000_0040; wvalid = 1'b1; wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bvalid[2] !== 1'b0 || awready[2] !== 1'b1 || wready[2] !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_state: bv/aw/w=%b%b%b want 011", bvalid[2], awready[2], wready[2]);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (bvalid[2] !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_no_resp%0d: bvalid=%b want 0", i, bvalid[2]);
      end
    end
    dbg_addr = 10'd16;
    #1;
    checks++;
    if (dbg_rdata[2] !== 32'h55AA_55AA) begin
      errors++;
      $display("FAIL rst_mid_mem: mem16=%h want 55aa55aa", dbg_rdata[2]);
    end
  endtask

  task automatic test_back_to_back();
    int k = 0;
    int nresp = 0;
    int cyc = 0;
    int last = -1;
    logic hs;
    do_reset();
    bready = 1'b1;
    while (nresp < 8 && cyc < 200) begin
      awvalid = (k < 8);
      wvalid  = (k < 8);
      awaddr  = 32'h0000_0100 + 32'(k) * 4;
      wdata   = 32'hA000_0000 | (32'(k) * 32'h0101);
      wstrb   = 4'hF;
      hs = (k < 8) && awready[0] && wready[0];
      tick();
      cyc++;
      if (hs) k++;
      if (bvalid[0]) begin
        checks++;
        if (bresp[0] !== 2'b00 || (last >= 0 && cyc - last != 3)) begin
          errors++;
          $display("FAIL b2b_resp%0d: bresp=%b gap=%0d want 00 gap 3", nresp, bresp[0], cyc - last);
        end
        last = cyc;
        nresp++;
      end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    checks++;
    if (nresp != 8) begin
      errors++;
      $display("FAIL b2b_count: got %0d responses want 8", nresp);
    end
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 10'(64 + i);
      #1;
      checks++;
      if (dbg_rdata[0] !== (32'hA000_0000 | (32'(i) * 32'h0101))) begin
        errors++;
        $display("FAIL b2b_data%0d: got %h want %h", i, dbg_rdata[0],
                 32'hA000_0000 | (32'(i) * 32'h0101));
      end
    end
  endtask

  initial begin
    rst = 1'b1; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    awaddr = '0; wdata = '0; wstrb = '0; dbg_addr = '0;
    test_reset();
    test_basic();
    test_strobe_order();
    test_out_of_range();
    test_latency_backpressure();
    test_reset_mid_write();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axil_wr_resp.md
# axil_wr_resp

AXI4-Lite write-channel responder for the pipeline CPU's data-side bus: the slave end of the AW/W/B handshake that the core's write master samples as awready, wready and bvalid. The block accepts address and data independently in either order and writes a word-addressed memory with byte strobes after a programmable latency. It then returns a write response. It serves as the simulation-side store target for the pipeline's memory stage.

## Interface
Parameters:
- DEPTH, 1024: number of 32-bit words in the backing memory; power of two.
- WR_LATENCY, 0: extra cycles spent in WRITE before commit; 0..15.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  reset, synchronous and active-high.
- awvalid  input  1  write-address valid.
- awready  output  1  write-address ready.
- awaddr  input  32  byte address.
- wvalid  input  1  write-data valid.
- wready  output  1  write-data ready.
- wdata  input  32  write data.
- wstrb  input  4  byte enables; bit i gates wdata[8i+7:8i].
- bvalid  output  1  write-response valid.
- bready  input  1  write-response ready.
- bresp  output  2  2'b00 OKAY, 2'b10 SLVERR.
- dbg_addr  input  log2(DEPTH)  word index for the verification read port.
- dbg_rdata  output  32  combinational read of mem[dbg_addr].

## Operation
- **Buffers.** AW buffer holds awaddr plus a full flag. W buffer holds wdata, wstrb plus a full flag.
  - awready = ~aw_full; wready = ~w_full. Both are registered-flag derived, with no combinational path from valid.
  - AW handshake (awvalid & awready at an edge) loads the AW buffer. W handshake loads the W buffer. Order is free, and both may occur at the same edge.
- **FSM: IDLE, WRITE, RESP.**
  - IDLE: when aw_full & w_full at an edge, go WRITE and load cnt = WR_LATENCY.
  - WRITE: if cnt != 0, decrement. If cnt == 0, commit, clear both full flags, go RESP, set bvalid = 1.
  - RESP: bvalid held, bresp stable, until bvalid & bready at an edge. Then bvalid = 0 and the FSM goes IDLE.
  - AW/W may be accepted during WRITE-after-commit and RESP (the buffers are empty). They are not processed until the FSM is back in IDLE.
- **Commit.**
  - Word index = aw_addr[2 +: log2(DEPTH)]. Bits [1:0] are ignored.
  - If aw_addr[31:2] < DEPTH: write each byte lane whose wstrb bit is set, and set bresp = OKAY.
  - Otherwise: no memory write, and bresp = SLVERR.
  - wstrb = 0 to an in-range address leaves memory unchanged, with bresp OKAY.
- **Reset.** Clears the FSM to IDLE, cnt = 0, both full flags, bvalid = 0, bresp = 00. Memory contents are not reset.
  - Reset mid-WRITE: the pending write is dropped with no commit.
  - Reset in RESP: the response is dropped.

## Timing
- **Reset values:** awready = 1, wready = 1, bvalid = 0, bresp = 2'b00. dbg_rdata reflects memory, which is unreset.
- **Latency.** With the last of AW/W accepted at edge t:
  - IDLE→WRITE at edge t+1.
  - Commit and bvalid rises at edge t+2+WR_LATENCY.
  - Memory holds the new value from that same edge.
- **Back-pressure.**
  - After the AW handshake, awready is 0 from the next cycle until the commit edge. W is symmetric.
  - A master holding awvalid stays stalled, and no data is lost.
- **Response hold.** bvalid stays high for any number of cycles with bready = 0, with bresp unchanged. With bready already high, bvalid lasts exactly one cycle.
- **Back-to-back throughput.** A second AW+W can be buffered during RESP. The next IDLE→WRITE occurs the edge after the B handshake, giving a minimum of 3+WR_LATENCY cycles per write.
- **Simultaneous events.**
  - A B handshake and a new AW/W handshake at the same edge are both honoured.
  - An AW handshake at the commit edge is impossible, because awready is 0 then.

## Test plan
- **Basic write.** Reset, WR_LATENCY=0; AW 0x0000_0010 and W 0xDEADBEEF/4'hF at the same edge, bready=1 → bvalid high exactly 2 cycles later for 1 cycle, bresp=00, dbg_addr=4 reads 0xDEADBEEF.
- **Strobes and ordering.** W 0x11223344/4'b0101 first, AW 0x10 three cycles later, over the previous value → mem[4]=0xDE22BE44. awready stays 1 and wready stays 0 until the commit.
- **Out of range.** DEPTH=1024; AW 0x0000_1000, W 0xFFFFFFFF/4'hF → bresp=2'b10; the memory word at index 0 is unchanged.
- **Latency and back-pressure.** WR_LATENCY=3, bready=0 for 10 cycles → bvalid rises at t+5 and stays high with constant bresp. A second AW/W is accepted during RESP and commits only after bready is raised.
- **Reset mid-operation.** Assert rst during WRITE with WR_LATENCY=5 → no memory change, bvalid=0, awready=wready=1 the cycle after reset.
- **Throughput.** 8 back-to-back writes with bready=1, WR_LATENCY=0 → 8 OKAY responses, one every 3 cycles, all 8 words correct via dbg_rdata.
